// File: rtl/csr_arb_pkg.sv
// Shared types and constants for the CSR arbiter: FSM states, CSR opcodes, command record.
// Latency: n/a (declarations only). Backpressure: n/a.
// The wait counter is 4 bits wide and saturates; sat_inc implements that increment.
package csr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 8;

    typedef struct packed {
        logic [11:0] address;
        logic [31:0] data;
        logic [1:0]  opcode;
        logic        wr_en;
    } csr_cmd_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/csr_arb_grant.sv
// Two-way grant select: one-hot grant among valid requests, tie broken by prio.
// Latency: combinational. Backpressure: no grant is ever given to an invalid request.
// prio names the requester that wins a tie (0 -> req0, 1 -> req1).
module csr_arb_grant (
    input  logic       req0,
    input  logic       req1,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            grant = prio ? 2'b10 : 2'b01;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/csr_arbiter.sv
// Arbitrates core and debug CSR requests onto one CSR-file command port, one command in flight.
// Latency: handshake T, command T+1, response T+3 with no trap/wait; timeout after TIMEOUT_CYCLES waits.
// Backpressure: ready only in IDLE outside trap cycles; CSR_ARB_RR_EN selects round-robin over fixed priority.
module csr_arbiter
    import csr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [11:0] req0_address_i,
    input  logic [31:0] req0_data_i,
    input  logic [1:0]  req0_opcode_i,
    input  logic        req0_wr_en_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [11:0] req1_address_i,
    input  logic [31:0] req1_data_i,
    input  logic [1:0]  req1_opcode_i,
    input  logic        req1_wr_en_i,

    output logic        rsp0_valid_o,
    output logic [31:0] rsp0_data_o,
    output logic        rsp0_excp_o,
    output logic        rsp1_valid_o,
    output logic [31:0] rsp1_data_o,
    output logic        rsp1_excp_o,

    output logic        tmu_valid_o,
    output logic [11:0] tmu_address_o,
    output logic [31:0] tmu_data_o,
    output logic [1:0]  tmu_opcode_o,
    output logic        tmu_wr_en_o,
    input  logic        tmu_done_i,
    input  logic        tmu_excp_i,
    input  logic [31:0] tmu_data_i,

    input  logic        trap_event_i
);

    arb_state_t  state_q;
    csr_cmd_t    cmd_q;
    csr_cmd_t    req0_cmd;
    csr_cmd_t    req1_cmd;
    logic        grant_id_q;
    logic [3:0]  wait_cnt_q;
    logic [3:0]  cnt_inc;
    logic        timeout_hit;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp0_data_q;
    logic [31:0] rsp1_data_q;
    logic        rsp0_excp_q;
    logic        rsp1_excp_q;

    logic        arb_en;
    logic        prio;
    logic [1:0]  grant;
    logic        handshake;
    logic [31:0] cap_data;
    logic        cap_excp;

    assign req0_cmd = '{address: req0_address_i, data: req0_data_i,
                        opcode: req0_opcode_i, wr_en: req0_wr_en_i};
    assign req1_cmd = '{address: req1_address_i, data: req1_data_i,
                        opcode: req1_opcode_i, wr_en: req1_wr_en_i};

    // Acceptance is suppressed in trap cycles and while reset is asserted.
    assign arb_en = (state_q == ST_IDLE) && !trap_event_i && !cpu_reset_i;

    csr_arb_grant u_grant (
        .req0  (req0_valid_i && arb_en),
        .req1  (req1_valid_i && arb_en),
        .prio  (prio),
        .grant (grant)
    );

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];
    assign handshake    = |grant;

`ifdef CSR_ARB_RR_EN
    // Holds the requester that was not granted last; it wins the next tie.
    logic prio_q;

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            prio_q <= 1'b0;
        end else if (handshake) begin
            prio_q <= grant[0];
        end
    end

    assign prio = prio_q;
`else
    assign prio = 1'b0;
`endif

    // The CSR file drops writes in trap cycles, so the issue pulse must track trap_event_i directly.
    assign tmu_valid_o = (state_q == ST_ISSUE) && !trap_event_i && !cpu_reset_i;

    assign cnt_inc     = sat_inc(wait_cnt_q);
    assign timeout_hit = ({28'd0, cnt_inc} == TIMEOUT_CYCLES);
    assign cap_data    = tmu_done_i ? tmu_data_i : 32'd0;
    assign cap_excp    = tmu_done_i ? tmu_excp_i : 1'b1;

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            grant_id_q  <= 1'b0;
            wait_cnt_q  <= 4'd0;
            rsp_valid_q <= 2'b00;
            rsp0_data_q <= 32'd0;
            rsp1_data_q <= 32'd0;
            rsp0_excp_q <= 1'b0;
            rsp1_excp_q <= 1'b0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        cmd_q      <= grant[1] ? req1_cmd : req0_cmd;
                        grant_id_q <= grant[1];
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!trap_event_i) begin
                        wait_cnt_q <= 4'd0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt_q <= cnt_inc;
                    // A real completion wins over a timeout landing in the same cycle.
                    if (tmu_done_i || timeout_hit) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= grant_id_q ? 2'b10 : 2'b01;
                        if (grant_id_q) begin
                            rsp1_data_q <= cap_data;
                            rsp1_excp_q <= cap_excp;
                        end else begin
                            rsp0_data_q <= cap_data;
                            rsp0_excp_q <= cap_excp;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tmu_address_o = cmd_q.address;
    assign tmu_data_o    = cmd_q.data;
    assign tmu_opcode_o  = cmd_q.opcode;
    assign tmu_wr_en_o   = cmd_q.wr_en;

    assign rsp0_valid_o = rsp_valid_q[0];
    assign rsp1_valid_o = rsp_valid_q[1];
    assign rsp0_data_o  = rsp0_data_q;
    assign rsp1_data_o  = rsp1_data_q;
    assign rsp0_excp_o  = rsp0_excp_q;
    assign rsp1_excp_o  = rsp1_excp_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter: a transaction table plus hand-written trap, timeout and reset sequences.
// Honours CSR_ARB_RR_EN for the expected tie-break grants.
module tb_csr_arbiter;
    import csr_arb_pkg::*;

    logic        cpu_clock_i;
    logic        cpu_reset_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [11:0] req0_address_i, req1_address_i;
    logic [31:0] req0_data_i, req1_data_i;
    logic [1:0]  req0_opcode_i, req1_opcode_i;
    logic        req0_wr_en_i, req1_wr_en_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic [31:0] rsp0_data_o, rsp1_data_o;
    logic        rsp0_excp_o, rsp1_excp_o;
    logic        tmu_valid_o;
    logic [11:0] tmu_address_o;
    logic [31:0] tmu_data_o;
    logic [1:0]  tmu_opcode_o;
    logic        tmu_wr_en_o;
    logic        tmu_done_i, tmu_excp_i;
    logic [31:0] tmu_data_i;
    logic        trap_event_i;

    csr_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .cpu_clock_i    (cpu_clock_i),
        .cpu_reset_i    (cpu_reset_i),
        .req0_valid_i   (req0_valid_i),
        .req0_ready_o   (req0_ready_o),
        .req0_address_i (req0_address_i),
        .req0_data_i    (req0_data_i),
        .req0_opcode_i  (req0_opcode_i),
        .req0_wr_en_i   (req0_wr_en_i),
        .req1_valid_i   (req1_valid_i),
        .req1_ready_o   (req1_ready_o),
        .req1_address_i (req1_address_i),
        .req1_data_i    (req1_data_i),
        .req1_opcode_i  (req1_opcode_i),
        .req1_wr_en_i   (req1_wr_en_i),
        .rsp0_valid_o   (rsp0_valid_o),
        .rsp0_data_o    (rsp0_data_o),
        .rsp0_excp_o    (rsp0_excp_o),
        .rsp1_valid_o   (rsp1_valid_o),
        .rsp1_data_o    (rsp1_data_o),
        .rsp1_excp_o    (rsp1_excp_o),
        .tmu_valid_o    (tmu_valid_o),
        .tmu_address_o  (tmu_address_o),
        .tmu_data_o     (tmu_data_o),
        .tmu_opcode_o   (tmu_opcode_o),
        .tmu_wr_en_o    (tmu_wr_en_o),
        .tmu_done_i     (tmu_done_i),
        .tmu_excp_i     (tmu_excp_i),
        .tmu_data_i     (tmu_data_i),
        .trap_event_i   (trap_event_i)
    );

    initial cpu_clock_i = 1'b0;
    always #5 cpu_clock_i = ~cpu_clock_i;

    logic [46:0]  tmu_fields;
    logic [117:0] all_out;
    assign tmu_fields = {tmu_address_o, tmu_data_o, tmu_opcode_o, tmu_wr_en_o};
    assign all_out = {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp0_data_o, rsp0_excp_o,
                      rsp1_valid_o, rsp1_data_o, rsp1_excp_o, tmu_valid_o, tmu_fields};

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [11:0] a0;
        logic [31:0] d0;
        logic [11:0] a1;
        logic [31:0] d1;
        logic [1:0]  op;
        logic        we;
        int          delay;
        logic [31:0] tdata;
        logic        texcp;
        logic [1:0]  exp_grant;
        logic [31:0] exp_data;
        logic        exp_excp;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] req, input logic [11:0] a0, input logic [31:0] d0,
                                input logic [11:0] a1, input logic [31:0] d1, input logic [1:0] op,
                                input logic we, input int delay, input logic [31:0] tdata,
                                input logic texcp, input logic [1:0] exp_grant,
                                input logic [31:0] exp_data, input logic exp_excp);
        vec_t v;
        v.req = req; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.op = op; v.we = we;
        v.delay = delay; v.tdata = tdata; v.texcp = texcp;
        v.exp_grant = exp_grant; v.exp_data = exp_data; v.exp_excp = exp_excp;
        return v;
    endfunction

    task automatic idle_inputs();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        tmu_done_i = 1'b0; tmu_excp_i = 1'b0; tmu_data_i = 32'd0;
        trap_event_i = 1'b0;
    endtask

    // Starts just after a falling edge with the DUT idle; returns likewise.
    task automatic run_txn(input vec_t v);
        logic [46:0] exp_cmd;
        logic        bad;
        exp_cmd = v.exp_grant[1] ? {v.a1, v.d1, v.op, v.we} : {v.a0, v.d0, v.op, v.we};
        req0_valid_i = v.req[0]; req0_address_i = v.a0; req0_data_i = v.d0;
        req0_opcode_i = v.op; req0_wr_en_i = v.we;
        req1_valid_i = v.req[1]; req1_address_i = v.a1; req1_data_i = v.d1;
        req1_opcode_i = v.op; req1_wr_en_i = v.we;
        #1;
        check("txn_ready", 128'({req1_ready_o, req0_ready_o}), 128'(v.exp_grant));
        @(negedge cpu_clock_i);
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        #1;
        check("txn_tmu_cmd", 128'({tmu_valid_o, tmu_fields}), 128'({1'b1, exp_cmd}));
        @(negedge cpu_clock_i);
        bad = 1'b0;
        for (int i = 0; i < v.delay; i++) begin
            #1;
            if (tmu_valid_o || rsp0_valid_o || rsp1_valid_o || tmu_fields !== exp_cmd) bad = 1'b1;
            @(negedge cpu_clock_i);
        end
        tmu_done_i = 1'b1; tmu_data_i = v.tdata; tmu_excp_i = v.texcp;
        #1;
        if (tmu_valid_o || rsp0_valid_o || rsp1_valid_o || tmu_fields !== exp_cmd) bad = 1'b1;
        check("txn_wait_quiet", 128'(bad), 128'(0));
        @(negedge cpu_clock_i);
        tmu_done_i = 1'b0; tmu_data_i = 32'd0; tmu_excp_i = 1'b0;
        #1;
        check("txn_rsp_valid", 128'({rsp1_valid_o, rsp0_valid_o}), 128'(v.exp_grant));
        check("txn_rsp_data", 128'(v.exp_grant[1] ? rsp1_data_o : rsp0_data_o), 128'(v.exp_data));
        check("txn_rsp_excp", 128'(v.exp_grant[1] ? rsp1_excp_o : rsp0_excp_o), 128'(v.exp_excp));
        @(negedge cpu_clock_i);
        #1;
        check("txn_rsp_hold", 128'({rsp1_valid_o, rsp0_valid_o,
                                    v.exp_grant[1] ? rsp1_data_o : rsp0_data_o}),
              128'({2'b00, v.exp_data}));
        @(negedge cpu_clock_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[6];
    vec_t post_rst;

    initial begin
        int pulses;
        logic bad;
        logic [46:0] held;
        logic [1:0] second_tie;

`ifdef CSR_ARB_RR_EN
        second_tie = 2'b10;
`else
        second_tie = 2'b01;
`endif
        //          req    a0      d0            a1      d1            op     we  dly tdata         ex  grant       data          ex
        vecs[0] = mk(2'b11, 12'h341, 32'h1111_0000, 12'h7B0, 32'h2222_0000, OP_RW, 1, 0, 32'h0000_0341, 0, 2'b01,      32'h0000_0341, 0);
        vecs[1] = mk(2'b11, 12'h342, 32'h0000_0033, 12'h7B1, 32'h0000_0044, OP_RS, 1, 1, 32'hCAFE_F00D, 0, second_tie, 32'hCAFE_F00D, 0);
        vecs[2] = mk(2'b01, 12'h300, 32'h0000_0000, 12'h000, 32'h0000_0000, OP_RW, 0, 0, 32'h0000_0088, 0, 2'b01,      32'h0000_0088, 0);
        vecs[3] = mk(2'b10, 12'h000, 32'h0000_0000, 12'hF11, 32'h0000_0005, OP_RW, 1, 0, 32'hDEAD_0000, 1, 2'b10,      32'hDEAD_0000, 1);
        vecs[4] = mk(2'b10, 12'h000, 32'h0000_0000, 12'h7B2, 32'h0000_000F, OP_RC, 1, 3, 32'h1234_5678, 0, 2'b10,      32'h1234_5678, 0);
        vecs[5] = mk(2'b01, 12'h344, 32'h0000_00F0, 12'h000, 32'h0000_0000, OP_RS, 1, 7, 32'hA5A5_5A5A, 0, 2'b01,      32'hA5A5_5A5A, 0);
        post_rst = mk(2'b11, 12'h305, 32'h0000_0101, 12'h7B3, 32'h0000_0202, OP_RW, 1, 2, 32'h0000_0505, 0, 2'b01,     32'h0000_0505, 0);

        req0_address_i = 12'd0; req0_data_i = 32'd0; req0_opcode_i = 2'd0; req0_wr_en_i = 1'b0;
        req1_address_i = 12'd0; req1_data_i = 32'd0; req1_opcode_i = 2'd0; req1_wr_en_i = 1'b0;
        idle_inputs();

        // Reset with a request and a completion present: everything must read 0.
        cpu_reset_i = 1'b1;
        req0_valid_i = 1'b1; tmu_done_i = 1'b1; tmu_data_i = 32'hFFFF_FFFF;
        repeat (2) @(negedge cpu_clock_i);
        #1;
        check("reset_outputs", 128'(all_out), 128'(0));
        @(negedge cpu_clock_i);
        cpu_reset_i = 1'b0;
        idle_inputs();
        @(negedge cpu_clock_i);

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Trap blocks acceptance in IDLE, then stalls the issue for three cycles.
        req0_valid_i = 1'b1; req0_address_i = 12'h345; req0_data_i = 32'h0000_0077;
        req0_opcode_i = OP_RW; req0_wr_en_i = 1'b1; trap_event_i = 1'b1;
        #1;
        check("trap_idle_ready", 128'({req1_ready_o, req0_ready_o}), 128'(2'b00));
        @(negedge cpu_clock_i);
        trap_event_i = 1'b0;
        #1;
        check("trap_handshake", 128'({req1_ready_o, req0_ready_o}), 128'(2'b01));
        @(negedge cpu_clock_i);
        req0_valid_i = 1'b0; trap_event_i = 1'b1;
        tmu_done_i = 1'b1; tmu_data_i = 32'h0000_0BAD;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (tmu_valid_o) pulses++;
            @(negedge cpu_clock_i);
            tmu_done_i = 1'b0; tmu_data_i = 32'd0;
        end
        trap_event_i = 1'b0;
        #1;
        check("trap_issue", 128'(tmu_valid_o), 128'(1));
        if (tmu_valid_o) pulses++;
        @(negedge cpu_clock_i);
        tmu_done_i = 1'b1; tmu_data_i = 32'h0000_0077;
        #1;
        if (tmu_valid_o) pulses++;
        @(negedge cpu_clock_i);
        tmu_done_i = 1'b0; tmu_data_i = 32'd0;
        #1;
        check("trap_rsp", 128'({rsp0_valid_o, rsp0_data_o, rsp0_excp_o}), 128'({1'b1, 32'h0000_0077, 1'b0}));
        check("trap_issue_once", 128'(pulses), 128'(1));
        @(negedge cpu_clock_i);

        // No completion: req1 must time out after eight WAIT cycles.
        req1_valid_i = 1'b1; req1_address_i = 12'h7B4; req1_data_i = 32'h0000_0003;
        req1_opcode_i = OP_RS; req1_wr_en_i = 1'b0;
        #1;
        check("timeout_handshake", 128'({req1_ready_o, req0_ready_o}), 128'(2'b10));
        @(negedge cpu_clock_i);
        req1_valid_i = 1'b0;
        #1;
        held = tmu_fields;
        check("timeout_tmu_cmd", 128'({tmu_valid_o, tmu_fields}), 128'({1'b1, 12'h7B4, 32'h0000_0003, OP_RS, 1'b0}));
        @(negedge cpu_clock_i);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (rsp0_valid_o || rsp1_valid_o || tmu_valid_o || tmu_fields !== held) bad = 1'b1;
            @(negedge cpu_clock_i);
        end
        check("timeout_wait_quiet", 128'(bad), 128'(0));
        #1;
        check("timeout_rsp", 128'({rsp0_valid_o, rsp1_valid_o, rsp1_data_o, rsp1_excp_o}),
              128'({1'b0, 1'b1, 32'h0000_0000, 1'b1}));
        @(negedge cpu_clock_i);

        // A completion in IDLE must be ignored.
        tmu_done_i = 1'b1; tmu_data_i = 32'h0000_0DDD;
        @(negedge cpu_clock_i);
        tmu_done_i = 1'b0; tmu_data_i = 32'd0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (rsp0_valid_o || rsp1_valid_o) bad = 1'b1;
            @(negedge cpu_clock_i);
        end
        check("stray_done_ignored", 128'(bad), 128'(0));

        // Reset while waiting: command dropped, outputs cleared, no response.
        req0_valid_i = 1'b1; req0_address_i = 12'h306; req0_data_i = 32'h0000_0009;
        req0_opcode_i = OP_RC; req0_wr_en_i = 1'b1;
        @(negedge cpu_clock_i);
        req0_valid_i = 1'b0;
        @(negedge cpu_clock_i);
        cpu_reset_i = 1'b1;
        @(negedge cpu_clock_i);
        cpu_reset_i = 1'b0;
        tmu_done_i = 1'b1; tmu_data_i = 32'h0000_0099;
        #1;
        check("reset_in_wait_outputs", 128'(all_out), 128'(0));
        @(negedge cpu_clock_i);
        tmu_done_i = 1'b0; tmu_data_i = 32'd0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (rsp0_valid_o || rsp1_valid_o || tmu_valid_o) bad = 1'b1;
            @(negedge cpu_clock_i);
        end
        check("reset_in_wait_no_rsp", 128'(bad), 128'(0));

        // After reset the tie-break starts again from req0.
        run_txn(post_rst);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
